// File: rtl/matrix_rx_deserializer_if.sv
// Serial result link from the array's output serializer, plus the rebuilt-matrix outputs.
interface matrix_rx_deserializer_if #(
  parameter int D_W = 8,
  parameter int N   = 2
);
  logic                   rx_bit;
  logic                   rx_valid;
  logic [N*N*2*D_W-1:0]   mat_out;
  logic                   mat_valid;
  logic                   busy;
  logic                   frame_err;

  modport master (
    output rx_bit, rx_valid,
    input  mat_out, mat_valid, busy, frame_err
  );

  modport slave (
    input  rx_bit, rx_valid,
    output mat_out, mat_valid, busy, frame_err
  );
endinterface

// File: rtl/matrix_rx_deserializer.sv
// Rebuilds an NxN matrix of 2*D_W-bit results from the 1-bit serial result stream.
// Optional macro RX_FRAME_CHECK_EN: pulse frame_err for one cycle on every aborted frame.
module matrix_rx_deserializer #(
  parameter int D_W = 8,
  parameter int N   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_rx_deserializer_if.slave bus
);
  localparam int EW  = 2 * D_W;
  localparam int NE  = N * N;
  localparam int MW  = NE * EW;
  localparam int BCW = $clog2(EW);
  localparam int ECW = $clog2(NE);

  typedef enum logic [1:0] {IDLE, RX, DONE} state_t;

  state_t         state, state_nxt;
  logic [BCW-1:0] bit_cnt;
  logic [ECW-1:0] elem_cnt;
  logic [EW-1:0]  sh_p0;
  logic [MW-1:0]  stage_p0;
  logic [MW-1:0]  mat_p1;
  logic           err_p1;
  logic [EW-1:0]  word;
  logic [MW-1:0]  merged;
  logic           sample;
  logic           abort;
  logic           elem_last;
  logic           frame_last;

  assign word       = {bus.rx_bit, sh_p0[EW-1:1]};
  assign elem_last  = (bit_cnt == BCW'(EW - 1));
  assign frame_last = elem_last && (elem_cnt == ECW'(NE - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          sample    = 1'b1;
          state_nxt = RX;
        end
      end
      RX: begin
        if (bus.rx_valid) begin
          sample = 1'b1;
          if (frame_last) state_nxt = DONE;
        end else begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final word is merged combinationally so mat_out lands in the same edge as the last bit.
  always_comb begin
    merged = stage_p0;
    merged[elem_cnt*EW +: EW] = word;
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      bit_cnt  <= '0;
      elem_cnt <= '0;
    end else if (sample) begin
      if (state == IDLE) begin
        bit_cnt  <= BCW'(1);
        elem_cnt <= '0;
      end else if (frame_last) begin
        bit_cnt  <= '0;
        elem_cnt <= '0;
      end else if (elem_last) begin
        bit_cnt  <= '0;
        elem_cnt <= elem_cnt + ECW'(1);
      end else begin
        bit_cnt  <= bit_cnt + BCW'(1);
      end
    end
  end

  // p0: shift register and staging buffer for the frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_p0    <= '0;
      stage_p0 <= '0;
    end else if (sample) begin
      sh_p0 <= word;
      if (state == RX && elem_last) stage_p0[elem_cnt*EW +: EW] <= word;
    end
  end

  // p1: published matrix, only touched by a complete frame
  always_ff @(posedge clk) begin
    if (rst)                                     mat_p1 <= '0;
    else if (sample && state == RX && frame_last) mat_p1 <= merged;
  end

`ifdef RX_FRAME_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err_p1 <= 1'b0;
    else     err_p1 <= abort;
  end
`else
  assign err_p1 = 1'b0;
`endif

  assign bus.mat_out   = mat_p1;
  assign bus.mat_valid = (state == DONE);
  assign bus.busy      = (state == RX);
  assign bus.frame_err = err_p1;
endmodule

// File: tb/tb_matrix_rx_deserializer.sv
// Directed bench for matrix_rx_deserializer (N=2, D_W=8): frames, gaps, aborts, reset, loopback.
module tb_matrix_rx_deserializer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic exp_err;

  matrix_rx_deserializer_if #(.D_W(8), .N(2)) bus ();

  matrix_rx_deserializer #(.D_W(8), .N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends nbits of m LSB first; a full frame (64) also checks the DONE cycle and the cycle after.
  task automatic send(input logic [63:0] m, input int nbits, input logic done_vld);
    for (int i = 0; i < nbits; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_bit   = m[i];
      step();
      if (i == 0)  chk("busy_first_bit", {63'd0, bus.busy}, 64'd1);
      if (i == 62) chk("no_early_valid", {63'd0, bus.mat_valid}, 64'd0);
      if (i == 63) begin
        chk("mat_valid_pulse", {63'd0, bus.mat_valid}, 64'd1);
        chk("mat_out_frame",   bus.mat_out, m);
        chk("busy_done",       {63'd0, bus.busy}, 64'd0);
      end
    end
    if (nbits == 64) begin
      bus.rx_valid = done_vld;
      bus.rx_bit   = 1'b1;
      step();
      chk("valid_one_cycle", {63'd0, bus.mat_valid}, 64'd0);
      chk("idle_after_done", {63'd0, bus.busy}, 64'd0);
      bus.rx_valid = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] a, b, c, d, e, prev, m;
`ifdef RX_FRAME_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    a = 64'hFFFF_0001_ABCD_1234;
    b = 64'h5A5A_5A5A_5A5A_5A5A;
    c = 64'h8001_7FFE_0F0F_C3A5;
    d = 64'h0123_4567_89AB_CDEF;
    e = 64'hDEAD_BEEF_0000_FFFF;

    rst = 1'b1; bus.rx_valid = 1'b0; bus.rx_bit = 1'b0;
    step(); step();
    chk("rst_mat_out",   bus.mat_out, 64'd0);
    chk("rst_mat_valid", {63'd0, bus.mat_valid}, 64'd0);
    chk("rst_busy",      {63'd0, bus.busy}, 64'd0);
    chk("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
    rst = 1'b0;
    step();

    // Reference frame, then a back-to-back frame after the mandatory single idle cycle
    send(a, 64, 1'b0);
    send(b, 64, 1'b0);
    chk("b2b_second", bus.mat_out, b);

    // Abort after 20 bits
    send(c, 20, 1'b0);
    bus.rx_valid = 1'b0;
    step();
    chk("abort_no_pulse", {63'd0, bus.mat_valid}, 64'd0);
    chk("abort_busy",     {63'd0, bus.busy}, 64'd0);
    chk("abort_keep_mat", bus.mat_out, b);
    chk("abort_err",      {63'd0, bus.frame_err}, {63'd0, exp_err});
    step();
    chk("abort_err_1cyc", {63'd0, bus.frame_err}, 64'd0);
    send(c, 64, 1'b0);

    // Abort exactly on an element boundary (after 32 bits)
    send(d, 32, 1'b0);
    bus.rx_valid = 1'b0;
    step();
    chk("abort_bnd_err",  {63'd0, bus.frame_err}, {63'd0, exp_err});
    chk("abort_bnd_keep", bus.mat_out, c);
    step();

    // Reset at bit 40
    send(d, 40, 1'b0);
    bus.rx_valid = 1'b1; bus.rx_bit = d[40]; rst = 1'b1;
    step();
    rst = 1'b0; bus.rx_valid = 1'b0;
    chk("midrst_busy",      {63'd0, bus.busy}, 64'd0);
    chk("midrst_mat_out",   bus.mat_out, 64'd0);
    chk("midrst_mat_valid", {63'd0, bus.mat_valid}, 64'd0);
    step();
    send(d, 64, 1'b0);

    // rx_valid held in DONE is ignored; idle toggling changes nothing
    send(e, 64, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.rx_valid = 1'b0;
      bus.rx_bit   = i[0];
      step();
    end
    chk("idle_toggle_busy",  {63'd0, bus.busy}, 64'd0);
    chk("idle_toggle_valid", {63'd0, bus.mat_valid}, 64'd0);
    chk("idle_toggle_mat",   bus.mat_out, e);

    // Loopback-style random frames with a 1-cycle gap
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 4; k++) m[k*16 +: 16] = 16'($urandom);
      prev = m;
      send(m, 64, 1'b0);
    end
    chk("loop_last", bus.mat_out, prev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
